// File: rtl/audio_out_capture.sv
// audio_out_capture: captures the left/right samples of each processed audio
// frame, packs them as {right, left} into a FIFO, and lets the host drain the
// FIFO and manage it through a small Wishbone register window.
module audio_out_capture #(
    parameter logic [7:0] ADDR   = 8'h65,
    parameter int         DEPTH  = 256,
    parameter int         CHAN_W = 3
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              in_we,
    input  logic [CHAN_W-1:0] in_addr,
    input  logic [15:0]       in_data,
    input  logic              frame_done,
    input  logic              wb_dbus_cyc,
    input  logic              wb_dbus_we,
    input  logic [31:0]       wb_dbus_adr,
    input  logic [31:0]       wb_dbus_dat,
    output logic              ack,
    output logic [31:0]       rdt,
    output logic              irq
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;

    logic [15:0]     left_q, right_q;
    logic            frame_q;

    logic [31:0]     mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [31:0]     head_q;

    logic            enable_q, enable_d;
    logic [7:0]      thr_q, thr_d;
    logic            ovf_q, ovf_d;
    logic            udf_q, udf_d;
    logic [15:0]     drop_q, drop_d;
    logic            irq_q;

    logic [1:0]      reg_q;
    logic            we_q;
    logic [15:0]     wdat_q;

    logic            sel;
    logic            empty, full;
    logic            push_ev, push_ok, drop_ev;
    logic            do_pop, do_udf, ctrl_wr, do_flush, do_clear;
    logic [31:0]     push_word;
    logic [31:0]     rd_mux;
    logic [15:0]     level16;

    // Bits of the bus and channel address that carry no meaning here
    logic            unused_bits;
    assign unused_bits = ^{in_addr[CHAN_W-1:1], wb_dbus_adr[23:4],
                           wb_dbus_adr[1:0], wb_dbus_dat[31:16], wdat_q[7:3]};

    assign sel       = wb_dbus_cyc && (wb_dbus_adr[31:24] == ADDR);
    assign empty     = (level_q == '0);
    assign full      = (level_q == LW'(DEPTH));
    assign level16   = 16'(level_q);
    assign push_word = {right_q, left_q};
    assign push_ev   = frame_done && !frame_q && enable_q;
    assign push_ok   = push_ev && !do_flush && (!full || do_pop);
    assign drop_ev   = push_ev && !do_flush && full && !do_pop;

    // Bus FSM state register; reset abandons any transfer in flight
    always_ff @(posedge ck) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Bus FSM next-state: accept a selected cycle, ack once, wait for cyc to drop
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel) state_d = S_ACK;
            S_ACK:   state_d = S_WAIT;
            S_WAIT:  if (!wb_dbus_cyc) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus FSM outputs: ack strobe and the register side effects of the ack cycle
    always_comb begin
        ack      = (state_q == S_ACK);
        do_pop   = ack && !we_q && (reg_q == 2'd0) && !empty;
        do_udf   = ack && !we_q && (reg_q == 2'd0) && empty;
        ctrl_wr  = ack && we_q && (reg_q == 2'd2);
        do_flush = ctrl_wr && wdat_q[2];
        do_clear = ctrl_wr && wdat_q[1];
    end

    // Capture register index and write data when a transfer is accepted
    always_ff @(posedge ck) begin
        if (rst) begin
            reg_q  <= '0;
            we_q   <= 1'b0;
            wdat_q <= '0;
        end else if (state_q == S_IDLE && sel) begin
            reg_q  <= wb_dbus_adr[3:2];
            we_q   <= wb_dbus_we;
            wdat_q <= wb_dbus_dat[15:0];
        end
    end

    // Read-data mux; only drives the bus while acking a read
    always_comb begin
        rd_mux = '0;
        case (reg_q)
            2'd0:    rd_mux = empty ? 32'd0 : head_q;
            2'd1:    rd_mux = {11'd0, enable_q, udf_q, ovf_q, full, empty, level16};
            2'd2:    rd_mux = {16'd0, thr_q, 7'd0, enable_q};
            default: rd_mux = {16'd0, drop_q};
        endcase
        rdt = (ack && !we_q) ? rd_mux : 32'd0;
    end

    // Sample latches and previous frame_done level for edge detection
    always_ff @(posedge ck) begin
        if (rst) begin
            left_q  <= '0;
            right_q <= '0;
            frame_q <= 1'b0;
        end else begin
            frame_q <= frame_done;
            if (in_we && !in_addr[0]) left_q  <= in_data;
            if (in_we &&  in_addr[0]) right_q <= in_data;
        end
    end

    // Next-state of FIFO pointers, level, control and sticky flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        enable_d = enable_q;
        thr_d    = thr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        drop_d   = drop_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_ok, do_pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (do_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
        if (ctrl_wr) begin
            enable_d = wdat_q[0];
            thr_d    = wdat_q[15:8];
        end
        if (do_clear) begin
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
            drop_d = '0;
        end
        if (do_udf) udf_d = 1'b1;
        if (drop_ev) begin
            ovf_d = 1'b1;
            if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
        end
    end

    // FIFO bookkeeping, control registers and registered interrupt
    always_ff @(posedge ck) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            enable_q <= 1'b0;
            thr_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            drop_q   <= '0;
            irq_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            enable_q <= enable_d;
            thr_q    <= thr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            drop_q   <= drop_d;
            irq_q    <= enable_q && (thr_q != 8'd0) && (level16 >= {8'd0, thr_q});
        end
    end

    assign irq = irq_q;

    // FIFO storage write port
    always_ff @(posedge ck) begin
        if (push_ok) mem[wr_ptr_q] <= push_word;
    end

    // Read-ahead of the head word, bypassing a word written into an empty FIFO
    always_ff @(posedge ck) begin
        if (rst)                                 head_q <= '0;
        else if (push_ok && wr_ptr_q == rd_ptr_q) head_q <= push_word;
        else                                     head_q <= mem[rd_ptr_q];
    end

endmodule
